// File: rtl/calc_pkg.sv
// Shared calculator definitions: token layout, opcodes, token classification
// and operator precedence. Also used by the number builder and the evaluator.
package calc_pkg;

  localparam int DEPTH  = 10;
  localparam int TOK_W  = 42;
  localparam int SIZE_W = $clog2(DEPTH + 1);

  // Token fields: {sign, mantissa, exp}
  localparam int SIGN_BIT = 41;
  localparam int MANT_HI  = 40;
  localparam int MANT_LO  = 7;
  localparam int EXP_HI   = 6;
  localparam int EXP_LO   = 0;

  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_SUB  = 8'hA1;
  localparam logic [7:0] OP_MUL  = 8'hA2;
  localparam logic [7:0] OP_DIV  = 8'hA3;
  localparam logic [7:0] OP_POW  = 8'hA4;
  localparam logic [7:0] OP_LPAR = 8'hB0;
  localparam logic [7:0] OP_RPAR = 8'hB1;

  typedef logic [TOK_W-1:0] tok_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN
  } state_e;

  // One action per clock, decoded from the current token and stack top.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_COPY_IN,
    ACT_PUSH,
    ACT_POP_DISCARD,
    ACT_POP_OUT,
    ACT_ABORT,
    ACT_TO_DRAIN,
    ACT_FINISH
  } act_e;

  // Upper 34 bits clear and low byte one of the seven opcodes.
  function automatic logic isOperator(tok_t t);
    return (t[TOK_W-1:8] == '0) &&
           (t[7:0] inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_POW, OP_LPAR, OP_RPAR});
  endfunction

  // Anything outside the reserved A0..BF opcode space is a number.
  function automatic logic isNumber(tok_t t);
    return !((t[TOK_W-1:8] == '0) && (t[7:0] >= 8'hA0) && (t[7:0] <= 8'hBF));
  endfunction

  function automatic logic [1:0] prec(logic [7:0] op);
    case (op)
      OP_ADD, OP_SUB: return 2'd1;
      OP_MUL, OP_DIV: return 2'd2;
      OP_POW:         return 2'd3;
      default:        return 2'd0;
    endcase
  endfunction

  function automatic logic rightAssoc(logic [7:0] op);
    return op == OP_POW;
  endfunction

endpackage

// File: rtl/infix_to_postfix_if.sv
// Handshake and token-array bundle between the number builder, this
// converter and the evaluator.
interface infix_to_postfix_if;
  import calc_pkg::*;

  logic                           start;
  logic [SIZE_W-1:0]              size;
  logic [DEPTH-1:0][TOK_W-1:0]    memIn;
  logic [SIZE_W-1:0]              postSize;
  logic [DEPTH-1:0][TOK_W-1:0]    memOut;
  logic                           done;
  logic                           error;

  modport master (
    output start, size, memIn,
    input  postSize, memOut, done, error
  );

  modport slave (
    input  start, size, memIn,
    output postSize, memOut, done, error
  );
endinterface

// File: rtl/op_stack.sv
// LIFO of 8-bit opcodes. Push and pop together overwrite the top entry.
module op_stack
  import calc_pkg::*;
#(
  parameter int N = DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_din,
  output logic [7:0] o_top,
  output logic       o_empty,
  output logic       o_full
);
  localparam int CW = $clog2(N + 1);

  logic [7:0]    r_mem [N];
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_top_idx;

  assign w_top_idx = r_cnt - CW'(1);
  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == CW'(N));
  assign o_top     = o_empty ? 8'h00 : r_mem[w_top_idx];

  // Stack pointer and storage update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      // NOTE: the storage is small, so it is cleared on reset too; this keeps
      // o_top free of X and costs only the reset fan-out on a handful of flops.
      for (int k = 0; k < N; k++) r_mem[k] <= 8'h00;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_push && i_pop && !o_empty) begin
      r_mem[w_top_idx] <= i_din;
    end else if (i_push && !o_full) begin
      r_mem[r_cnt] <= i_din;
      r_cnt        <= r_cnt + CW'(1);
    end else if (i_pop && !o_empty) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/infix_to_postfix.sv
// Shunting-yard converter: infix token array in, postfix token array out,
// one push, pop or copy per clock.
module infix_to_postfix
  import calc_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  infix_to_postfix_if.slave  bus
);

  state_e                     r_state;
  logic [SIZE_W-1:0]          r_i;
  logic [SIZE_W-1:0]          r_o;
  logic [DEPTH-1:0][TOK_W-1:0] r_mem_out;
  logic                       r_done;
  logic                       r_error;

  tok_t       w_tok;
  logic [7:0] w_op;
  logic [7:0] w_top;
  logic       w_empty;
  logic       w_full;
  logic       w_top_is_op;
  act_e       w_act;
  logic       w_push;
  logic       w_pop;
  logic       w_clr;

  assign w_op        = w_tok[7:0];
  assign w_top_is_op = !w_empty && (w_top != OP_LPAR);
  assign w_push      = (w_act == ACT_PUSH);
  assign w_pop       = (w_act == ACT_POP_DISCARD) || (w_act == ACT_POP_OUT);
  assign w_clr       = (r_state == ST_IDLE) && bus.start;

  op_stack #(.N(DEPTH)) u_stack (
    .clk     (clock),
    .rst_n   (reset),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_op),
    .o_top   (w_top),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Decode this cycle's single action from state, current token and stack top.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_act = ACT_NONE;
    w_tok = '0;
    if (r_i < SIZE_W'(DEPTH)) w_tok = bus.memIn[r_i];

    case (r_state)
      ST_SCAN: begin
        if (r_i >= bus.size) begin
          w_act = ACT_TO_DRAIN;
        end else if (isNumber(w_tok)) begin
          w_act = ACT_COPY_IN;
        end else if (!isOperator(w_tok)) begin
          w_act = ACT_ABORT;
        end else if (w_op == OP_LPAR) begin
          w_act = w_full ? ACT_ABORT : ACT_PUSH;
        end else if (w_op == OP_RPAR) begin
          if (w_empty)               w_act = ACT_ABORT;
          else if (w_top == OP_LPAR) w_act = ACT_POP_DISCARD;
          else                       w_act = ACT_POP_OUT;
        end else if (w_top_is_op &&
                     ((prec(w_top) > prec(w_op)) ||
                      ((prec(w_top) == prec(w_op)) && !rightAssoc(w_op)))) begin
          w_act = ACT_POP_OUT;
        end else begin
          w_act = w_full ? ACT_ABORT : ACT_PUSH;
        end
      end
      ST_DRAIN: begin
        if (w_empty)               w_act = ACT_FINISH;
        else if (w_top == OP_LPAR) w_act = ACT_ABORT;
        else                       w_act = ACT_POP_OUT;
      end
      default: w_act = ACT_NONE;
    endcase
  end

  // Control FSM with registered outputs; a run starts only from IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_i       <= '0;
      r_o       <= '0;
      r_mem_out <= '0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (bus.start) begin
          r_i       <= '0;
          r_o       <= '0;
          r_error   <= 1'b0;
          r_mem_out <= '0;
          r_state   <= ST_SCAN;
        end
      end else begin
        case (w_act)
          ACT_COPY_IN: begin
            r_mem_out[r_o] <= w_tok;
            r_o            <= r_o + SIZE_W'(1);
            r_i            <= r_i + SIZE_W'(1);
          end
          ACT_PUSH, ACT_POP_DISCARD: begin
            r_i <= r_i + SIZE_W'(1);
          end
          ACT_POP_OUT: begin
            r_mem_out[r_o] <= {{(TOK_W-8){1'b0}}, w_top};
            r_o            <= r_o + SIZE_W'(1);
          end
          ACT_ABORT: begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
          ACT_TO_DRAIN: begin
            r_state <= ST_DRAIN;
          end
          ACT_FINISH: begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // The output count register doubles as postSize, so it tracks every write.
  assign bus.postSize = r_o;
  assign bus.memOut   = r_mem_out;
  assign bus.done     = r_done;
  assign bus.error    = r_error;

endmodule

// File: tb/tb_infix_to_postfix.sv
// Bench for infix_to_postfix: directed cases plus random token streams,
// all checked against a queue-based shunting-yard reference model.
module tb_infix_to_postfix;
  import calc_pkg::*;

  typedef logic [DEPTH-1:0][TOK_W-1:0] mem_t;

  logic clock;
  logic reset;
  int   n_total;
  int   n_bad;
  int   q[$];

  infix_to_postfix_if bus ();

  infix_to_postfix dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int tb_prec(logic [7:0] b);
    case (b)
      8'hA0, 8'hA1: return 1;
      8'hA2, 8'hA3: return 2;
      8'hA4:        return 3;
      default:      return 0;
    endcase
  endfunction

  // Reference: classic shunting-yard over a byte queue; steps counts clock
  // edges from the start edge to the edge that registers done.
  task automatic ref_model(input mem_t toks, input int n, output mem_t eout,
                           output int eo, output bit eerr, output int steps);
    logic [7:0] stk[$];
    logic [7:0] b;
    bit         hi0;
    bit         fin;
    int         i;
    eout = '0; eo = 0; eerr = 0; steps = 0; i = 0; fin = 0;
    while (!fin && i < n) begin
      steps++;
      hi0 = (toks[i][TOK_W-1:8] == '0);
      b   = toks[i][7:0];
      if (!hi0 || b < 8'hA0 || b > 8'hBF) begin
        eout[eo] = toks[i]; eo++; i++;
      end else if (b == 8'hB0) begin
        if (stk.size() >= DEPTH) begin eerr = 1; fin = 1; end
        else begin stk.push_back(b); i++; end
      end else if (b == 8'hB1) begin
        if (stk.size() == 0) begin eerr = 1; fin = 1; end
        else if (stk[$] == 8'hB0) begin void'(stk.pop_back()); i++; end
        else begin eout[eo] = {{(TOK_W-8){1'b0}}, stk.pop_back()}; eo++; end
      end else if (b > 8'hA4) begin
        eerr = 1; fin = 1;
      end else if (stk.size() > 0 && stk[$] != 8'hB0 &&
                   (tb_prec(stk[$]) > tb_prec(b) ||
                    (tb_prec(stk[$]) == tb_prec(b) && b != 8'hA4))) begin
        eout[eo] = {{(TOK_W-8){1'b0}}, stk.pop_back()}; eo++;
      end else begin
        if (stk.size() >= DEPTH) begin eerr = 1; fin = 1; end
        else begin stk.push_back(b); i++; end
      end
    end
    if (!fin) begin
      steps++;
      while (1) begin
        steps++;
        if (stk.size() == 0) break;
        if (stk[$] == 8'hB0) begin eerr = 1; break; end
        eout[eo] = {{(TOK_W-8){1'b0}}, stk.pop_back()}; eo++;
      end
    end
  endtask

  // Run the expression held in q; optionally fire a stray start mid-run.
  task automatic run_case(input string name, input bit inject);
    mem_t toks;
    mem_t eout;
    int   eo, elat, lat;
    bit   eerr;
    toks = '0;
    for (int k = 0; k < q.size() && k < DEPTH; k++) toks[k] = TOK_W'(q[k]);
    ref_model(toks, q.size(), eout, eo, eerr, elat);

    @(negedge clock);
    bus.memIn = toks;
    bus.size  = SIZE_W'(q.size());
    bus.start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock);
      #1;
      if (bus.done) begin lat = k; break; end
      if (inject) bus.start = (k == 2);
    end
    bus.start = 1'b0;

    check({name, ".latency"}, 64'(lat), 64'(elat));
    check({name, ".error"}, 64'(bus.error), 64'(eerr));
    check({name, ".postSize"}, 64'(bus.postSize), 64'(eo));
    for (int k = 0; k < DEPTH; k++)
      check($sformatf("%s.memOut[%0d]", name, k), 64'(bus.memOut[k]), 64'(eout[k]));
    @(posedge clock);
    #1;
    check({name, ".done_one_cycle"}, 64'(bus.done), 64'(0));
  endtask

  initial begin
    int seen;
    int r;
    n_total   = 0;
    n_bad     = 0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.size  = '0;
    bus.memIn = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset.postSize", 64'(bus.postSize), 64'(0));
    check("reset.done", 64'(bus.done), 64'(0));
    check("reset.error", 64'(bus.error), 64'(0));
    check("reset.memOut_zero", 64'(bus.memOut == '0), 64'(1));
    @(negedge clock);
    reset = 1'b1;

    q = {32'h180, 32'hA0, 32'h200, 32'hA2, 32'h100};
    run_case("3+4*2", 1'b0);
    q = {32'hB0, 32'h180, 32'hA0, 32'h200, 32'hB1, 32'hA2, 32'h100};
    run_case("(3+4)*2", 1'b0);
    q = {32'h100, 32'hA4, 32'h180, 32'hA4, 32'h100};
    run_case("2^3^2", 1'b0);
    q = {32'h400, 32'hA1, 32'h100, 32'hA1, 32'h80};
    run_case("8-2-1", 1'b0);
    q = {32'hB1, 32'h180};
    run_case("rpar_first", 1'b0);
    q = {32'hB0, 32'h180};
    run_case("open_paren", 1'b0);
    q.delete();
    run_case("size0", 1'b0);
    q = {32'h180, 32'hA5, 32'h200};
    run_case("invalid_A5", 1'b0);
    q = {32'hB0, 32'h180, 32'hA0, 32'h200, 32'hB1, 32'hA2, 32'h100};
    run_case("start_in_scan", 1'b1);

    // Reset in the middle of a scan: outputs clear at once, no done pulse.
    @(negedge clock);
    bus.memIn = '0;
    for (int k = 0; k < 9; k++) bus.memIn[k] = (k % 2 == 0) ? TOK_W'(32'h180) : TOK_W'(32'hA2);
    bus.size  = SIZE_W'(9);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst.postSize", 64'(bus.postSize), 64'(0));
    check("midrst.memOut_zero", 64'(bus.memOut == '0), 64'(1));
    check("midrst.error", 64'(bus.error), 64'(0));
    seen = 0;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (bus.done) seen++;
    end
    check("midrst.no_done", 64'(seen), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    q = {32'h180, 32'hA0, 32'h200, 32'hA2, 32'h100};
    run_case("after_reset", 1'b0);

    // Random token streams, biased toward well-formed fragments.
    for (int t = 0; t < 40; t++) begin
      q.delete();
      for (int k = 0; k < $urandom_range(0, DEPTH); k++) begin
        r = $urandom_range(0, 99);
        if (r < 45)      q.push_back(int'($urandom_range(1, 500)) << 7);
        else if (r < 85) q.push_back(32'hA0 + int'($urandom_range(0, 4)));
        else if (r < 92) q.push_back(32'hB0);
        else if (r < 98) q.push_back(32'hB1);
        else             q.push_back(32'hA5 + int'($urandom_range(0, 26)));
      end
      run_case($sformatf("rand%0d", t), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
